cga_vram_sched: RTL and testbench

//  Time-slot scheduler for the single-port CGA video SRAM. It shares the SRAM between
//  the CRTC pixel fetch (character byte + attribute byte) and one host (ISA) read/write

---
 rtl/cga_vram_sched.sv | 178 +++++++++++++++++
 tb/tb_cga_vram_sched.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cga_vram_sched.sv
// cga_vram_sched
//   Time-slot scheduler for the single-port CGA video SRAM. Each character
//   period is SLOTS clocks long. Slot 0 fetches the character byte and slot 1
//   fetches the attribute byte for the CRTC. The remaining slots serve one
//   host (ISA) read or write at a time.
//
//   Ports:
//     clk, reset              system clock and synchronous active-high reset
//     slot_sync               the next cycle is slot 0 of a new character period
//     pix_addr                character-byte address (the attribute byte follows it)
//     pix_char/pix_attr       latched pixel bytes
//     pix_valid/pix_snow      update pulse; pix_snow is set when a byte was forced to FF
//     cpu_req/we/addr/din     host request strobe and its operands
//     cpu_dout/busy/ack       host read data, busy flag, completion pulse
//     ram_a/dout/d_oe         SRAM address, write data and data-bus drive enable
//     ram_din                 SRAM read data (asynchronous SRAM)
//     ram_oe_l/ram_we_l       SRAM output and write enables (active low)
module cga_vram_sched #(
  parameter int SLOTS     = 8,
  parameter int PIX_SLOTS = 2,
  parameter int SNOW      = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        slot_sync,
  input  logic [18:0] pix_addr,
  output logic [7:0]  pix_char,
  output logic [7:0]  pix_attr,
  output logic        pix_valid,
  output logic        pix_snow,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [18:0] cpu_addr,
  input  logic [7:0]  cpu_din,
  output logic [7:0]  cpu_dout,
  output logic        cpu_busy,
  output logic        cpu_ack,
  output logic [18:0] ram_a,
  output logic [7:0]  ram_dout,
  output logic        ram_d_oe,
  input  logic [7:0]  ram_din,
  output logic        ram_oe_l,
  output logic        ram_we_l
);

  localparam int SW = (SLOTS > 1) ? $clog2(SLOTS) : 1;
  localparam logic [SW-1:0] LAST_S  = SW'(SLOTS - 1);
  localparam logic [SW-1:0] PIX_S   = SW'(PIX_SLOTS);
  localparam logic [SW-1:0] WR_MAX  = SW'(SLOTS - 3);
  localparam logic [SW-1:0] CHAR_S  = '0;
  localparam logic [SW-1:0] ATTR_S  = SW'(1);
  localparam bit            SNOW_EN = (SNOW != 0);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_WR_SETUP,
    ST_WR_STROBE,
    ST_WR_HOLD
  } state_t;

  state_t        state_reg;
  logic [SW-1:0] slot_reg;
  logic [SW-1:0] slot_next;
  logic          busy_reg;
  logic          pend_we_reg;
  logic [18:0]   pend_addr_reg;
  logic [7:0]    pend_data_reg;
  logic          ack_reg;
  logic [7:0]    dout_reg;
  logic [7:0]    char_reg;
  logic [7:0]    attr_reg;
  logic          valid_reg;
  logic          snow_reg;
  logic          snow_char_reg;
  logic          host_state;
  logic          rd_ok;
  logic          wr_ok;

  // Start decisions look at the slot the first host cycle will occupy
  // (slot_next), so a write never spills into the next period's pixel slots.
  always_comb begin
    slot_next  = (slot_sync || slot_reg == LAST_S) ? '0 : slot_reg + SW'(1);
    host_state = (state_reg != ST_IDLE);
    rd_ok      = SNOW_EN || (slot_next >= PIX_S);
    wr_ok      = SNOW_EN || ((slot_next >= PIX_S) && (slot_next <= WR_MAX));
  end

  // The SRAM address follows the host op whenever a host state is active, even
  // in a pixel slot; the pixel byte fetched in that slot is replaced by FF.
  always_comb begin
    ram_a = pix_addr;
    if (host_state)
      ram_a = pend_addr_reg;
    else if (slot_reg == ATTR_S)
      ram_a = pix_addr + 19'd1;
  end

  // Strobes are decoded from the state register only, so they cannot glitch.
  assign ram_oe_l  = (state_reg == ST_WR_SETUP) || (state_reg == ST_WR_STROBE) ||
                     (state_reg == ST_WR_HOLD);
  assign ram_we_l  = (state_reg != ST_WR_STROBE);
  assign ram_d_oe  = (state_reg == ST_WR_STROBE) || (state_reg == ST_WR_HOLD);
  assign ram_dout  = pend_data_reg;
  assign pix_char  = char_reg;
  assign pix_attr  = attr_reg;
  assign pix_valid = valid_reg;
  assign pix_snow  = snow_reg;
  assign cpu_dout  = dout_reg;
  assign cpu_busy  = busy_reg;
  assign cpu_ack   = ack_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= ST_IDLE;
      slot_reg      <= '0;
      busy_reg      <= 1'b0;
      pend_we_reg   <= 1'b0;
      pend_addr_reg <= '0;
      pend_data_reg <= '0;
      ack_reg       <= 1'b0;
      dout_reg      <= '0;
      char_reg      <= '0;
      attr_reg      <= '0;
      valid_reg     <= 1'b0;
      snow_reg      <= 1'b0;
      snow_char_reg <= 1'b0;
    end else begin
      slot_reg <= slot_next;
      ack_reg  <= 1'b0;

      // A request while busy is simply dropped.
      if (cpu_req && !busy_reg) begin
        busy_reg      <= 1'b1;
        pend_we_reg   <= cpu_we;
        pend_addr_reg <= cpu_addr;
        pend_data_reg <= cpu_din;
      end

      case (state_reg)
        ST_IDLE: begin
          if (busy_reg) begin
            if (pend_we_reg) begin
              if (wr_ok) state_reg <= ST_WR_SETUP;
            end else if (rd_ok) begin
              state_reg <= ST_RD;
            end
          end
        end
        ST_RD: begin
          dout_reg  <= ram_din;
          ack_reg   <= 1'b1;
          busy_reg  <= 1'b0;
          state_reg <= ST_IDLE;
        end
        ST_WR_SETUP:  state_reg <= ST_WR_STROBE;
        ST_WR_STROBE: state_reg <= ST_WR_HOLD;
        ST_WR_HOLD: begin
          ack_reg   <= 1'b1;
          busy_reg  <= 1'b0;
          state_reg <= ST_IDLE;
        end
        default: state_reg <= ST_IDLE;
      endcase

      // Pixel fetch: a slot taken by the host yields "snow" (FF).
      if (slot_reg == CHAR_S) begin
        char_reg      <= host_state ? 8'hFF : ram_din;
        snow_char_reg <= host_state;
      end
      if (slot_reg == ATTR_S)
        attr_reg <= host_state ? 8'hFF : ram_din;
      valid_reg <= (slot_reg == ATTR_S);
      snow_reg  <= (slot_reg == ATTR_S) && (snow_char_reg || host_state);
    end
  end

endmodule

// File: tb/tb_cga_vram_sched.sv
module tb_cga_vram_sched;

  typedef struct {
    logic       is_rd;
    logic [7:0] data;
    int         ack_slot;
  } op_t;

  typedef struct {
    logic [7:0] ch;
    logic [7:0] at;
    logic       sn;
  } px_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        slot_sync;
  logic [18:0] pix_addr;

  // Instance 0: SNOW=0, instance 1: SNOW=1. They share clock, reset, sync and pix_addr.
  logic [7:0]  pix_char0, pix_attr0, cpu_dout0, cpu_din0, ram_dout0, ram_din0;
  logic        pix_valid0, pix_snow0, cpu_req0, cpu_we0, cpu_busy0, cpu_ack0;
  logic        ram_d_oe0, ram_oe_l0, ram_we_l0;
  logic [18:0] cpu_addr0, ram_a0;
  logic [7:0]  pix_char1, pix_attr1, cpu_dout1, cpu_din1, ram_dout1, ram_din1;
  logic        pix_valid1, pix_snow1, cpu_req1, cpu_we1, cpu_busy1, cpu_ack1;
  logic        ram_d_oe1, ram_oe_l1, ram_we_l1;
  logic [18:0] cpu_addr1, ram_a1;

  cga_vram_sched #(.SLOTS(8), .PIX_SLOTS(2), .SNOW(0)) u_dut (
    .clk(clk), .reset(reset), .slot_sync(slot_sync), .pix_addr(pix_addr),
    .pix_char(pix_char0), .pix_attr(pix_attr0), .pix_valid(pix_valid0), .pix_snow(pix_snow0),
    .cpu_req(cpu_req0), .cpu_we(cpu_we0), .cpu_addr(cpu_addr0), .cpu_din(cpu_din0),
    .cpu_dout(cpu_dout0), .cpu_busy(cpu_busy0), .cpu_ack(cpu_ack0),
    .ram_a(ram_a0), .ram_dout(ram_dout0), .ram_d_oe(ram_d_oe0), .ram_din(ram_din0),
    .ram_oe_l(ram_oe_l0), .ram_we_l(ram_we_l0)
  );

  cga_vram_sched #(.SLOTS(8), .PIX_SLOTS(2), .SNOW(1)) u_snow (
    .clk(clk), .reset(reset), .slot_sync(slot_sync), .pix_addr(pix_addr),
    .pix_char(pix_char1), .pix_attr(pix_attr1), .pix_valid(pix_valid1), .pix_snow(pix_snow1),
    .cpu_req(cpu_req1), .cpu_we(cpu_we1), .cpu_addr(cpu_addr1), .cpu_din(cpu_din1),
    .cpu_dout(cpu_dout1), .cpu_busy(cpu_busy1), .cpu_ack(cpu_ack1),
    .ram_a(ram_a1), .ram_dout(ram_dout1), .ram_d_oe(ram_d_oe1), .ram_din(ram_din1),
    .ram_oe_l(ram_oe_l1), .ram_we_l(ram_we_l1)
  );

  // Asynchronous SRAM models (addresses alias on the low 12 bits).
  logic [7:0] mem0 [0:4095];
  logic [7:0] mem1 [0:4095];
  assign ram_din0 = mem0[ram_a0[11:0]];
  assign ram_din1 = mem1[ram_a1[11:0]];
  always @(posedge clk) if (!ram_we_l0 && ram_d_oe0) mem0[ram_a0[11:0]] <= ram_dout0;
  always @(posedge clk) if (!ram_we_l1 && ram_d_oe1) mem1[ram_a1[11:0]] <= ram_dout1;

  // Reference slot position of the current cycle.
  int tb_slot = 0;
  always @(posedge clk) begin
    if (reset || slot_sync) tb_slot <= 0;
    else                    tb_slot <= (tb_slot == 7) ? 0 : tb_slot + 1;
  end

  int checks = 0;
  int failures = 0;
  op_t q0[$];
  op_t q1[$];
  px_t pq0[$];
  px_t pq1[$];
  int ack_cnt0 = 0, ack_cnt1 = 0, we_cnt0 = 0, we_cnt1 = 0;
  int exp_we0 = 0, exp_we1 = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Completion / pixel / strobe monitors, sampled on the falling edge.
  always @(negedge clk) begin
    if (cpu_ack0) begin
      ack_cnt0++;
      if (q0.size() == 0) check("ack0_unexpected", 1, 0);
      else begin
        op_t e;
        e = q0.pop_front();
        if (e.is_rd) check("rd_data0", cpu_dout0, e.data);
        check("ack_slot0", tb_slot, e.ack_slot);
        check("busy_at_ack0", cpu_busy0, 0);
        $display("txn dut0 %s ack slot=%0d dout=%02h", e.is_rd ? "RD" : "WR", tb_slot, cpu_dout0);
      end
    end
    if (cpu_ack1) begin
      ack_cnt1++;
      if (q1.size() == 0) check("ack1_unexpected", 1, 0);
      else begin
        op_t e;
        e = q1.pop_front();
        if (e.is_rd) check("rd_data1", cpu_dout1, e.data);
        check("ack_slot1", tb_slot, e.ack_slot);
        $display("txn dut1 %s ack slot=%0d dout=%02h", e.is_rd ? "RD" : "WR", tb_slot, cpu_dout1);
      end
    end
    if (pix_valid0 && pq0.size() != 0) begin
      px_t p;
      p = pq0.pop_front();
      check("pix_char0", pix_char0, p.ch);
      check("pix_attr0", pix_attr0, p.at);
      check("pix_snow0", pix_snow0, p.sn);
      $display("txn dut0 PIX char=%02h attr=%02h snow=%0d", pix_char0, pix_attr0, pix_snow0);
    end
    if (pix_valid1 && pq1.size() != 0) begin
      px_t p;
      p = pq1.pop_front();
      check("pix_char1", pix_char1, p.ch);
      check("pix_attr1", pix_attr1, p.at);
      check("pix_snow1", pix_snow1, p.sn);
      $display("txn dut1 PIX char=%02h attr=%02h snow=%0d", pix_char1, pix_attr1, pix_snow1);
    end
    if (!ram_we_l0) begin
      we_cnt0++;
      check("we_slot0", tb_slot, exp_we0);
      check("d_oe_strobe0", ram_d_oe0, 1);
      check("oe_l_strobe0", ram_oe_l0, 1);
    end
    if (!ram_we_l1) begin
      we_cnt1++;
      check("we_slot1", tb_slot, exp_we1);
      check("d_oe_strobe1", ram_d_oe1, 1);
    end
  end

  task automatic wait_slot(input int s);
    int n = 0;
    @(negedge clk);
    while (tb_slot != s && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (tb_slot != s) check("slot_timeout", tb_slot, s);
  endtask

  task automatic drain();
    int n = 0;
    while ((q0.size() + q1.size() + pq0.size() + pq1.size()) != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("drain", q0.size() + q1.size() + pq0.size() + pq1.size(), 0);
  endtask

  task automatic host0(input logic we, input logic [18:0] a, input logic [7:0] d);
    cpu_req0  = 1'b1;
    cpu_we0   = we;
    cpu_addr0 = a;
    cpu_din0  = d;
    @(negedge clk);
    cpu_req0  = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int c0, w0;
    for (int i = 0; i < 4096; i++) begin
      mem0[i] <= 8'h00;
      mem1[i] <= 8'h00;
    end
    mem0[12'h100] <= 8'h41; mem1[12'h100] <= 8'h41;
    mem0[12'h101] <= 8'h07; mem1[12'h101] <= 8'h07;
    mem0[12'h200] <= 8'h5A; mem1[12'h200] <= 8'h5A;
    mem0[12'hFFF] <= 8'hAB; mem1[12'hFFF] <= 8'hAB;
    mem0[12'h000] <= 8'hCD; mem1[12'h000] <= 8'hCD;
    reset = 1'b1; slot_sync = 1'b0; pix_addr = 19'h00100;
    cpu_req0 = 0; cpu_we0 = 0; cpu_addr0 = '0; cpu_din0 = '0;
    cpu_req1 = 0; cpu_we1 = 0; cpu_addr1 = '0; cpu_din1 = '0;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_char", pix_char0, 8'h00);
    check("rst_attr", pix_attr0, 8'h00);
    check("rst_valid", pix_valid0, 0);
    check("rst_snow", pix_snow0, 0);
    check("rst_dout", cpu_dout0, 8'h00);
    check("rst_busy", cpu_busy0, 0);
    check("rst_ack", cpu_ack0, 0);
    check("rst_we_l", ram_we_l0, 1);
    check("rst_oe_l", ram_oe_l0, 0);
    check("rst_d_oe", ram_d_oe0, 0);
    check("rst_ram_a", ram_a0, 19'h00100);

    // 1: first pixel fetch after reset
    pq0.push_back(px_t'{8'h41, 8'h07, 1'b0});
    pq1.push_back(px_t'{8'h41, 8'h07, 1'b0});
    reset = 1'b0;
    drain();

    // 2: read requested in slot 0 -> RD in slot 2, ack in slot 3
    wait_slot(0);
    q0.push_back(op_t'{1'b1, 8'h5A, 3});
    host0(1'b0, 19'h00200, 8'h00);
    check("busy_after_req", cpu_busy0, 1);
    @(negedge clk);
    check("rd_ram_a", ram_a0, 19'h00200);
    check("rd_oe_l", ram_oe_l0, 0);
    drain();

    // 3: write requested in slot 6 is deferred to slot 2 (strobe in slot 3)
    wait_slot(6);
    exp_we0 = 3;
    w0 = we_cnt0;
    q0.push_back(op_t'{1'b0, 8'h00, 5});
    pq0.push_back(px_t'{8'h41, 8'h07, 1'b0});
    host0(1'b1, 19'h00300, 8'hC3);
    drain();
    check("wr_mem300", mem0[12'h300], 8'hC3);
    check("wr_we_cycles", we_cnt0 - w0, 1);

    // Latest write start that still fits: requested in slot 3, strobe in slot 6
    wait_slot(3);
    exp_we0 = 6;
    w0 = we_cnt0;
    q0.push_back(op_t'{1'b0, 8'h00, 0});
    host0(1'b1, 19'h00302, 8'h3C);
    drain();
    check("wr_mem302", mem0[12'h302], 8'h3C);
    check("wr_we_cycles2", we_cnt0 - w0, 1);

    // 5: second request while busy is ignored
    wait_slot(0);
    c0 = ack_cnt0;
    q0.push_back(op_t'{1'b1, 8'hC3, 3});
    host0(1'b0, 19'h00300, 8'h00);
    host0(1'b1, 19'h00201, 8'hEE);
    drain();
    repeat (16) @(negedge clk);
    check("single_ack", ack_cnt0 - c0, 1);
    check("ignored_mem201", mem0[12'h201], 8'h00);

    // 4: SNOW=1 write whose strobe lands in slot 0
    wait_slot(5);
    exp_we1 = 0;
    q1.push_back(op_t'{1'b0, 8'h00, 2});
    pq1.push_back(px_t'{8'hFF, 8'hFF, 1'b1});
    cpu_req1 = 1'b1; cpu_we1 = 1'b1; cpu_addr1 = 19'h00400; cpu_din1 = 8'h99;
    @(negedge clk);
    cpu_req1 = 1'b0;
    drain();
    check("snow_mem400", mem1[12'h400], 8'h99);
    pq1.push_back(px_t'{8'h41, 8'h07, 1'b0});
    drain();

    // Attribute address wraps at the top of the 19-bit space
    wait_slot(7);
    pix_addr = 19'h7FFFF;
    pq0.push_back(px_t'{8'hAB, 8'hCD, 1'b0});
    pq1.push_back(px_t'{8'hAB, 8'hCD, 1'b0});
    @(negedge clk);
    check("wrap_char_a", ram_a0, 19'h7FFFF);
    @(negedge clk);
    check("wrap_attr_a", ram_a0, 19'h00000);
    drain();
    wait_slot(7);
    pix_addr = 19'h00100;

    // 6: reset during WR_STROBE
    wait_slot(0);
    exp_we0 = 3;
    host0(1'b1, 19'h00500, 8'h77);
    @(negedge clk);
    check("setup_oe_l", ram_oe_l0, 1);
    check("setup_we_l", ram_we_l0, 1);
    @(negedge clk);
    check("strobe_we_l", ram_we_l0, 0);
    c0 = ack_cnt0;
    reset = 1'b1;
    @(negedge clk);
    check("rstwr_we_l", ram_we_l0, 1);
    check("rstwr_d_oe", ram_d_oe0, 0);
    check("rstwr_busy", cpu_busy0, 0);
    check("rstwr_ack", cpu_ack0, 0);
    reset = 1'b0;
    repeat (20) @(negedge clk);
    check("rstwr_no_ack", ack_cnt0 - c0, 0);

    // slot_sync in slot 5 restarts the period; then a normal 8-cycle wrap
    wait_slot(5);
    slot_sync = 1'b1;
    @(negedge clk);
    slot_sync = 1'b0;
    check("sync_s0_valid", pix_valid0, 0);
    @(negedge clk);
    check("sync_s1_valid", pix_valid0, 0);
    @(negedge clk);
    check("sync_s2_valid", pix_valid0, 1);
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      check("wrap_valid", pix_valid0, (i == 8) ? 1 : 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
